// File: rtl/debouncer_array.sv
`default_nettype none
// ============================================================================
// Module   : debouncer_array
// Brief    : Per-channel switch debouncer with edge ticks and optional
//            long-press detection (enabled by macro DEBOUNCER_ARRAY_HOLD_EN).
// Revision : 1.0
// ============================================================================
module debouncer_array #(
  parameter int CHANNELS    = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INTERVAL_MS = 40,
  parameter int HOLD_MS     = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sw,
  output logic [CHANNELS-1:0] db_level,
  output logic [CHANNELS-1:0] rise_tick,
  output logic [CHANNELS-1:0] fall_tick,
  output logic [CHANNELS-1:0] hold_tick,
  output logic                any_event
);

  localparam int DB_CYCLES = (CLK_FREQ_HZ / 1000) * INTERVAL_MS;
  localparam int CNT_W     = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef DEBOUNCER_ARRAY_HOLD_EN
  localparam int HOLD_CYCLES = (CLK_FREQ_HZ / 1000) * HOLD_MS;
  localparam int HOLD_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("debouncer_array: HOLD_CYCLES must be at least 1");
  end
`endif

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_RISE_WAIT = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_FALL_WAIT = 2'd3;

  if (DB_CYCLES < 2 || CHANNELS < 1 || CHANNELS > 32 || HOLD_MS < 0) begin : g_bad_cfg
    $error("debouncer_array: illegal parameters (DB_CYCLES must be >= 2, CHANNELS 1..32)");
  end

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;
  logic                any_event_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, fall_q;
    logic             ch_rise_d, ch_fall_d;
    logic             sw_sync;

    assign sw_sync = sync2_q[i];

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      db_d      = db_q;
      ch_rise_d = 1'b0;
      ch_fall_d = 1'b0;
      case (state_q)
        ST_LOW: begin
          db_d = 1'b0;
          if (sw_sync) begin
            state_d = ST_RISE_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_RISE_WAIT: begin
          if (!sw_sync) begin
            state_d = ST_LOW;
          end else if (cnt_q == '0) begin
            state_d   = ST_HIGH;
            db_d      = 1'b1;
            ch_rise_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_HIGH: begin
          db_d = 1'b1;
          if (!sw_sync) begin
            state_d = ST_FALL_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_FALL_WAIT: begin
          if (sw_sync) begin
            state_d = ST_HIGH;
          end else if (cnt_q == '0) begin
            state_d   = ST_LOW;
            db_d      = 1'b0;
            ch_fall_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
          db_d    = 1'b0;
        end
      endcase
    end

    // Reset drops the channel straight to LOW; an in-flight fall is abandoned.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_LOW;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        rise_q  <= ch_rise_d;
        fall_q  <= ch_fall_d;
      end
    end

    assign rise_d[i]    = ch_rise_d;
    assign fall_d[i]    = ch_fall_d;
    assign db_level[i]  = db_q;
    assign rise_tick[i] = rise_q;
    assign fall_tick[i] = fall_q;

`ifdef DEBOUNCER_ARRAY_HOLD_EN
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_q, hold_d;

    // Counter saturates so the long-press tick fires once per press.
    always_comb begin
      hold_cnt_d = hold_cnt_q;
      hold_d     = 1'b0;
      if (!db_q) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
        hold_d     = (hold_cnt_q == HOLD_LAST);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        hold_cnt_q <= '0;
        hold_q     <= 1'b0;
      end else begin
        hold_cnt_q <= hold_cnt_d;
        hold_q     <= hold_d;
      end
    end

    assign hold_tick[i] = hold_q;
`else
    assign hold_tick[i] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_event_q <= 1'b0;
    end else begin
      any_event_q <= |(rise_d | fall_d);
    end
  end

  assign any_event = any_event_q;

endmodule
`default_nettype wire

// File: doc/debouncer_array.md
DEBOUNCER_ARRAY -- requirements
Module: debouncer_array

Interface
REQ-001 Parameter CHANNELS, default 4, meaning number of independent input channels (legal 1..32).
REQ-002 Parameter CLK_FREQ_HZ, default 50_000_000, meaning clock frequency in Hz.
REQ-003 Parameter INTERVAL_MS, default 40, meaning debounce stable time in ms.
REQ-004 Parameter HOLD_MS, default 1000, meaning long-press threshold in ms, used only under the configuration macro.
REQ-005 clk  input  1  rising-edge clock; the block has one clock; reset is synchronous and active-high.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 sw  input  CHANNELS  raw asynchronous switch inputs, one bit per channel.
REQ-008 db_level  output  CHANNELS  registered debounced level per channel.
REQ-009 rise_tick  output  CHANNELS  one-cycle pulse per channel on each debounced 0->1.
REQ-010 fall_tick  output  CHANNELS  one-cycle pulse per channel on each debounced 1->0.
REQ-011 hold_tick  output  CHANNELS  one-cycle pulse per channel on a long press.
REQ-012 any_event  output  1  registered OR of all rise_tick and fall_tick bits, in the same cycle as those ticks.

Function
REQ-013 DB_CYCLES SHALL equal (CLK_FREQ_HZ/1000)*INTERVAL_MS, and HOLD_CYCLES SHALL equal (CLK_FREQ_HZ/1000)*HOLD_MS; both are integer arithmetic, and elaboration SHALL fail if DB_CYCLES < 2.
REQ-014 Counter width SHALL be the minimum needed to hold DB_CYCLES-1, and HOLD_CYCLES respectively.
REQ-015 Each sw bit SHALL pass through a 2-flop synchronizer; sw_sync is the second flop's output.
REQ-016 Each channel SHALL run an independent 4-state FSM: LOW, RISE_WAIT, HIGH, FALL_WAIT, with a private down-counter.
REQ-017 LOW: if sw_sync=1, go to RISE_WAIT and load cnt=DB_CYCLES-1.
REQ-018 RISE_WAIT: if sw_sync=0, return to LOW immediately, with no tick (glitch abort); otherwise decrement cnt.
REQ-019 RISE_WAIT with cnt=0 and sw_sync=1: go to HIGH; at the same edge db_level<=1 and rise_tick<=1 for one cycle.
REQ-020 HIGH: if sw_sync=0, go to FALL_WAIT and load cnt=DB_CYCLES-1.
REQ-021 FALL_WAIT: if sw_sync=1, return to HIGH with no tick; otherwise decrement cnt; at cnt=0 with sw_sync=0, go to LOW, and db_level<=0 and fall_tick<=1 for one cycle.
REQ-022 Latency: if sw[i] is first sampled high at edge P0 and stays high, db_level[i] and rise_tick[i] SHALL be high after edge P0+DB_CYCLES+2; the same applies symmetrically for falls.
REQ-023 Any sw_sync pulse shorter than DB_CYCLES+1 cycles SHALL produce no db_level change and no tick.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL assert every corresponding tick bit in the same cycle.
REQ-025 The counter SHALL never wrap: it is loaded only on entry to a WAIT state and is not decremented below 0.
REQ-026 An unreachable FSM encoding SHALL recover to LOW on the next edge with outputs 0.

Reset
REQ-027 While reset=1 at a clock edge: all FSMs go to LOW; synchronizers, counters and hold counters clear; db_level, rise_tick, fall_tick, hold_tick and any_event all become 0.
REQ-028 Reset mid-operation (any WAIT or HIGH state) SHALL abandon the operation with no fall_tick; after release, the channel re-qualifies from LOW.

Configuration
REQ-029 Macro DEBOUNCER_ARRAY_HOLD_EN defined: each channel has a hold counter that clears while db_level=0 and counts while db_level=1, saturating at HOLD_CYCLES.
REQ-030 With DEBOUNCER_ARRAY_HOLD_EN, hold_tick[i] SHALL pulse exactly once, HOLD_CYCLES cycles after the rise_tick[i] cycle, provided db_level[i] stayed 1 throughout; time spent in FALL_WAIT counts as high.
REQ-031 Macro not defined: hold_tick SHALL be constant 0, no hold counters are synthesized, and HOLD_MS is ignored.

Verification (CHANNELS=4, CLK_FREQ_HZ=1000, INTERVAL_MS=4 -> DB_CYCLES=4, HOLD_MS=10 -> HOLD_CYCLES=10)
REQ-032 sw=4'b0001 held from edge 0 -> db_level[0]=1 and rise_tick[0]=1 after edge 6, for exactly one cycle; any_event=1 in that cycle; other channels stay 0.
REQ-033 sw[1] pulses high for 3 cycles, then low -> db_level[1] stays 0 and no tick occurs on any channel.
REQ-034 sw[2] high and stable, then toggles low for 2 cycles -> no fall_tick and db_level[2] remains 1; a later sustained low -> fall_tick[2] 6 edges after the first low sample.
REQ-035 sw=4'b1111 applied in a single cycle and held -> rise_tick=4'b1111 in the same cycle.
REQ-036 sw[3] qualified high, then reset asserted for 1 cycle -> db_level[3]=0 with no fall_tick; with sw[3] still high, rise_tick[3] 6 edges after release.
REQ-037 Macro defined, sw[0] held 20 cycles -> hold_tick[0] pulses once, 10 cycles after rise_tick[0]; macro undefined -> hold_tick stays 0.
